// File: rtl/dmem_arb_pkg.sv
// Shared types and encodings for the two-port DataMemory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_P0   = 2'b01;
  localparam logic [1:0] OWNER_P1   = 2'b10;

  function automatic logic [1:0] owner_of(input arb_state_e s);
    logic [1:0] o;
    o = OWNER_NONE;
    case (s)
      LOCK0:   o = OWNER_P0;
      LOCK1:   o = OWNER_P1;
      default: o = OWNER_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational two-way round-robin pick; on a tie the port that did not win last is chosen.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic pick0,
  output logic pick1
);

  // last == 1 means port 1 won most recently, so port 0 takes a tie
  always_comb begin
    pick0 = req0 & (~req1 | last);
    pick1 = req1 & (~req0 | ~last);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port DataMemory with round-robin and bounded lock bursts.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic              r0_lock,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic              r1_lock,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_e       state, state_nxt;
  logic             last, last_nxt;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
  logic             pick0, pick1;
  logic             g0, g1;

  dmem_rr_pick u_pick (
    .req0  (r0_req),
    .req1  (r1_req),
    .last  (last),
    .pick0 (pick0),
    .pick1 (pick1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_nxt     = last;
    lock_cnt_nxt = lock_cnt;
    g0           = 1'b0;
    g1           = 1'b0;
    // grants are suppressed while reset is asserted, even with requests pending
    if (rst_n) begin
      case (state)
        IDLE: begin
          g0 = pick0;
          g1 = pick1;
          if (g0) begin
            last_nxt = 1'b0;
            if (r0_lock) begin
              state_nxt    = LOCK0;
              lock_cnt_nxt = CNT_ONE;
            end
          end else if (g1) begin
            last_nxt = 1'b1;
            if (r1_lock) begin
              state_nxt    = LOCK1;
              lock_cnt_nxt = CNT_ONE;
            end
          end
        end
        LOCK0: begin
          g0           = r0_req;
          lock_cnt_nxt = lock_cnt + CNT_ONE;
          if (g0) last_nxt = 1'b0;
          if (!r0_lock || lock_cnt == CNT_MAX) begin
            state_nxt    = IDLE;
            lock_cnt_nxt = '0;
          end
        end
        LOCK1: begin
          g1           = r1_req;
          lock_cnt_nxt = lock_cnt + CNT_ONE;
          if (g1) last_nxt = 1'b1;
          if (!r1_lock || lock_cnt == CNT_MAX) begin
            state_nxt    = IDLE;
            lock_cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt    = IDLE;
          lock_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    mem_rw    = MEM_READ;
    mem_addr  = '0;
    mem_wdata = '0;
    if (g0) begin
      mem_rw    = r0_we;
      mem_addr  = r0_addr;
      mem_wdata = r0_wdata;
    end else if (g1) begin
      mem_rw    = r1_we;
      mem_addr  = r1_addr;
      mem_wdata = r1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
    end else begin
      r0_rvalid <= g0 & (r0_we == MEM_READ);
      r1_rvalid <= g1 & (r1_we == MEM_READ);
    end
  end

  assign r0_gnt   = g0;
  assign r1_gnt   = g1;
  assign r0_rdata = mem_rdata;
  assign r1_rdata = mem_rdata;
  assign owner    = owner_of(state);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural DataMemory and shadow memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
  logic [7:0]  r0_addr, r1_addr;
  logic [15:0] r0_wdata, r1_wdata;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [15:0] r0_rdata, r1_rdata;
  logic        mem_rw;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [1:0]  owner;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem    [256];
  logic [15:0] shadow [256];
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic        exp_rv0 = 1'b0;
  logic        exp_rv1 = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_LOCK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner(owner)
  );

  // single-port memory with registered read data
  always @(posedge clk) begin
    if (mem_rw) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive0(input logic req, input logic we, input logic lock,
                        input logic [7:0] addr, input logic [15:0] wdata);
    r0_req = req; r0_we = we; r0_lock = lock; r0_addr = addr; r0_wdata = wdata;
  endtask

  task automatic drive1(input logic req, input logic we, input logic lock,
                        input logic [7:0] addr, input logic [15:0] wdata);
    r1_req = req; r1_we = we; r1_lock = lock; r1_addr = addr; r1_wdata = wdata;
  endtask

  // check one cycle against expected grants/owner, then advance past the posedge
  task automatic cyc(input logic eg0, input logic eg1, input logic [1:0] eo);
    logic [15:0] d;
    @(negedge clk);
    check("gnt0", 32'(r0_gnt), 32'(eg0));
    check("gnt1", 32'(r1_gnt), 32'(eg1));
    check("owner", 32'(owner), 32'(eo));
    check("rvalid0", 32'(r0_rvalid), 32'(exp_rv0));
    check("rvalid1", 32'(r1_rvalid), 32'(exp_rv1));
    if (exp_rv0 && q0.size() > 0) begin
      d = q0.pop_front();
      check("rdata0", 32'(r0_rdata), 32'(d));
    end
    if (exp_rv1 && q1.size() > 0) begin
      d = q1.pop_front();
      check("rdata1", 32'(r1_rdata), 32'(d));
    end
    if (eg0) begin
      check("mem_rw", 32'(mem_rw), 32'(r0_we));
      check("mem_addr", 32'(mem_addr), 32'(r0_addr));
      if (r0_we) check("mem_wdata", 32'(mem_wdata), 32'(r0_wdata));
    end else if (eg1) begin
      check("mem_rw", 32'(mem_rw), 32'(r1_we));
      check("mem_addr", 32'(mem_addr), 32'(r1_addr));
      if (r1_we) check("mem_wdata", 32'(mem_wdata), 32'(r1_wdata));
    end else begin
      check("idle_rw", 32'(mem_rw), 32'(0));
      check("idle_addr", 32'(mem_addr), 32'(0));
      check("idle_wdata", 32'(mem_wdata), 32'(0));
    end
    exp_rv0 = eg0 && !r0_we;
    exp_rv1 = eg1 && !r1_we;
    if (eg0) begin
      if (r0_we) shadow[r0_addr] = r0_wdata;
      else q0.push_back(shadow[r0_addr]);
    end
    if (eg1) begin
      if (r1_we) shadow[r1_addr] = r1_wdata;
      else q1.push_back(shadow[r1_addr]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end
    rst_n = 1'b0;
    drive0(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive1(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rvalid0", 32'(r0_rvalid), 32'(0));
    check("rst_rvalid1", 32'(r1_rvalid), 32'(0));
    check("rst_owner", 32'(owner), 32'(0));
    rst_n = 1'b1;

    // write then read the same address back-to-back
    drive0(1'b1, 1'b1, 1'b0, 8'h10, 16'h1234); cyc(1'b1, 1'b0, 2'b00);
    drive0(1'b1, 1'b0, 1'b0, 8'h10, 16'h0000); cyc(1'b1, 1'b0, 2'b00);
    drive0(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000); cyc(1'b0, 1'b0, 2'b00);

    // port 1 write leaves last=1, so the tie sequence starts at port 0
    drive1(1'b1, 1'b1, 1'b0, 8'h20, 16'hBEEF); cyc(1'b0, 1'b1, 2'b00);
    drive0(1'b1, 1'b0, 1'b0, 8'h10, 16'h0000);
    drive1(1'b1, 1'b0, 1'b0, 8'h20, 16'h0000);
    cyc(1'b1, 1'b0, 2'b00);
    cyc(1'b0, 1'b1, 2'b00);
    cyc(1'b1, 1'b0, 2'b00);
    cyc(1'b0, 1'b1, 2'b00);
    drive0(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive1(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    cyc(1'b0, 1'b0, 2'b00);

    // port 1 locked burst stalls port 0 for three cycles
    drive0(1'b1, 1'b1, 1'b0, 8'h30, 16'h1111); cyc(1'b1, 1'b0, 2'b00);
    drive0(1'b1, 1'b0, 1'b0, 8'h31, 16'h0000);
    drive1(1'b1, 1'b1, 1'b1, 8'h30, 16'h0A0A); cyc(1'b0, 1'b1, 2'b00);
    drive1(1'b1, 1'b1, 1'b1, 8'h31, 16'h0B0B); cyc(1'b0, 1'b1, 2'b10);
    drive1(1'b1, 1'b1, 1'b0, 8'h32, 16'h0C0C); cyc(1'b0, 1'b1, 2'b10);
    drive1(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000); cyc(1'b1, 1'b0, 2'b00);
    drive0(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000); cyc(1'b0, 1'b0, 2'b00);

    // port 0 holds lock past MAX_LOCK; forced release hands the tie to port 1
    drive0(1'b1, 1'b1, 1'b1, 8'h40, 16'h5000); cyc(1'b1, 1'b0, 2'b00);
    drive1(1'b1, 1'b0, 1'b0, 8'h40, 16'h0000);
    for (int i = 1; i <= 8; i++) begin
      drive0(1'b1, 1'b1, 1'b1, 8'(8'h40 + i), 16'(16'h5000 + i));
      cyc(1'b1, 1'b0, 2'b01);
    end
    drive0(1'b1, 1'b1, 1'b1, 8'h49, 16'h5009); cyc(1'b0, 1'b1, 2'b00);
    drive0(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive1(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    cyc(1'b0, 1'b0, 2'b00);

    // reset in the cycle after a read grant drops the pending rvalid
    drive0(1'b1, 1'b0, 1'b0, 8'h10, 16'h0000); cyc(1'b1, 1'b0, 2'b00);
    drive1(1'b1, 1'b0, 1'b0, 8'h20, 16'h0000);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid0", 32'(r0_rvalid), 32'(0));
    check("mid_rst_rvalid1", 32'(r1_rvalid), 32'(0));
    check("mid_rst_owner", 32'(owner), 32'(0));
    check("mid_rst_gnt0", 32'(r0_gnt), 32'(0));
    check("mid_rst_gnt1", 32'(r1_gnt), 32'(0));
    exp_rv0 = 1'b0;
    exp_rv1 = 1'b0;
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 2'b00);
    drive0(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    cyc(1'b0, 1'b1, 2'b00);
    drive1(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    cyc(1'b0, 1'b0, 2'b00);

    // idle bus
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
